// File: rtl/lr35902_mbc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : lr35902_mbc_pkg                                                  |
// | Purpose : Shared types and constants for the MBC1 cartridge bank control.  |
// |           Register-select encoding (CPU adr[14:13]), bank sizes, the RAM   |
// |           enable key and the bank-1 zero-fix helper.                       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package lr35902_mbc_pkg;

  // Register selected by adr[14:13] of a write into 0x0000-0x7fff
  typedef enum logic [1:0] {
    MBC_RAMEN = 2'd0,
    MBC_BANK1 = 2'd1,
    MBC_BANK2 = 2'd2,
    MBC_MODE  = 2'd3
  } mbc_reg_t;

  localparam int         ROM_BANK_BYTES = 16384;
  localparam int         RAM_BANK_BYTES = 8192;
  localparam logic [3:0] RAM_EN_KEY     = 4'ha;

  // Bank 0 can never be mapped into the upper ROM window; the whole 5-bit
  // field is tested, so 0x20/0x40/0x60 become 0x21/0x41/0x61.
  function automatic logic [4:0] bank1_eff(input logic [4:0] bank1);
    return (bank1 == 5'd0) ? 5'd1 : bank1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lr35902_mbc1_regs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lr35902_mbc1_regs                                                |
// | Purpose : MBC1 control registers. Commits exactly one register write per   |
// |           rising edge of the write strobe while cs_rom is selected.        |
// | Ports   : clk, reset_n (sync, active low)                                  |
// |           i_write   CPU write strobe (level)                               |
// |           i_cs_rom  ROM-area select (0x0000-0x7fff)                        |
// |           i_sel     CPU adr[14:13], picks the target register              |
// |           i_din     CPU write data                                         |
// |           o_ram_en, o_bank1[4:0], o_bank2[1:0], o_mode                     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module lr35902_mbc1_regs
  import lr35902_mbc_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_write,
  input  logic       i_cs_rom,
  input  logic [1:0] i_sel,
  input  logic [7:0] i_din,
  output logic       o_ram_en,
  output logic [4:0] o_bank1,
  output logic [1:0] o_bank2,
  output logic       o_mode
);

  logic       r_write_q;
  logic       r_ram_en;
  logic [4:0] r_bank1;
  logic [1:0] r_bank2;
  logic       r_mode;

  logic       w_commit;
  mbc_reg_t   w_target;
  logic       w_unused_din;

  // Edge detect: a held strobe commits only on its first cycle. write_q is
  // cleared by reset, so a strobe held across reset release commits once.
  assign w_commit     = i_cs_rom & i_write & ~r_write_q;
  assign w_target     = mbc_reg_t'(i_sel);
  assign w_unused_din = ^i_din[7:5];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_write_q <= 1'b0;
      r_ram_en  <= 1'b0;
      r_bank1   <= 5'd0;
      r_bank2   <= 2'd0;
      r_mode    <= 1'b0;
    end else begin
      r_write_q <= i_write;
      if (w_commit) begin
        case (w_target)
          MBC_RAMEN: r_ram_en <= (i_din[3:0] == RAM_EN_KEY);
          MBC_BANK1: r_bank1  <= i_din[4:0];
          MBC_BANK2: r_bank2  <= i_din[1:0];
          MBC_MODE:  r_mode   <= i_din[0];
          default:   r_mode   <= r_mode;
        endcase
      end
    end
  end

  assign o_ram_en = r_ram_en;
  assign o_bank1  = r_bank1;
  assign o_bank2  = r_bank2;
  assign o_mode   = r_mode;

endmodule
`default_nettype wire

// File: rtl/lr35902_mbc1.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lr35902_mbc1                                                     |
// | Purpose : MBC1 cartridge bank controller. Latches bank/control writes to   |
// |           0x0000-0x7fff and maps CPU addresses onto physical cartridge     |
// |           ROM/RAM addresses. Outputs are combinational from adr + regs.    |
// | Params  : ROM_BANKS (2..128, power of 2), RAM_BANKS (0,1,2,4; 0 = no RAM)  |
// | Ports   : clk, reset_n (sync, active low)                                  |
// |           adr[15:0], din[7:0], write, cs_rom, cs_xram   (CPU side)         |
// |           rom_adr[20:0], ram_adr[14:0], ram_cs, ram_we, open_bus           |
// | Config  : LR35902_MBC1_MULTICART_EN - MBC1M wiring (bank1[4] not used for  |
// |           addressing; bank2 lands on bits [5:4] of the bank number)        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module lr35902_mbc1
  import lr35902_mbc_pkg::*;
#(
  parameter int ROM_BANKS = 128,
  parameter int RAM_BANKS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] adr,
  input  logic [7:0]  din,
  input  logic        write,
  input  logic        cs_rom,
  input  logic        cs_xram,
  output logic [20:0] rom_adr,
  output logic [14:0] ram_adr,
  output logic        ram_cs,
  output logic        ram_we,
  output logic        open_bus
);

  localparam logic [20:0] c_ROM_MASK = 21'(ROM_BANKS * ROM_BANK_BYTES - 1);

  logic       w_ram_en;
  logic [4:0] w_bank1;
  logic [1:0] w_bank2;
  logic       w_mode;
  logic [4:0] w_bank1_eff;
  logic [6:0] w_upper_bank;
  logic [6:0] w_lower_bank;
  logic [6:0] w_rom_bank;
  logic [1:0] w_rbank;
  logic       w_unused_adr;

  lr35902_mbc1_regs u_regs (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_write  (write),
    .i_cs_rom (cs_rom),
    .i_sel    (adr[14:13]),
    .i_din    (din),
    .o_ram_en (w_ram_en),
    .o_bank1  (w_bank1),
    .o_bank2  (w_bank2),
    .o_mode   (w_mode)
  );

  assign w_bank1_eff = bank1_eff(w_bank1);

`ifdef LR35902_MBC1_MULTICART_EN
  logic w_unused_b1;
  // Multicart boards route bank2 onto bank bits [5:4]; bank1[4] only feeds
  // the zero check.
  assign w_upper_bank = {1'b0, w_bank2, w_bank1_eff[3:0]};
  assign w_lower_bank = w_mode ? {1'b0, w_bank2, 4'b0000} : 7'd0;
  assign w_unused_b1  = w_bank1_eff[4];
`else
  assign w_upper_bank = {w_bank2, w_bank1_eff};
  assign w_lower_bank = w_mode ? {w_bank2, 5'b00000} : 7'd0;
`endif

  assign w_rom_bank   = adr[14] ? w_upper_bank : w_lower_bank;
  assign rom_adr      = {w_rom_bank, adr[13:0]} & c_ROM_MASK;
  assign w_rbank      = w_mode ? w_bank2 : 2'd0;
  assign w_unused_adr = adr[15];

  generate
    if (RAM_BANKS == 0) begin : g_no_ram
      logic w_unused_ram;
      assign w_unused_ram = ^{w_ram_en, w_rbank};
      assign ram_cs       = 1'b0;
      assign ram_adr      = 15'd0;
    end else begin : g_ram
      localparam logic [14:0] c_RAM_MASK = 15'(RAM_BANKS * RAM_BANK_BYTES - 1);
      assign ram_cs  = cs_xram & w_ram_en;
      assign ram_adr = {w_rbank, adr[12:0]} & c_RAM_MASK;
    end
  endgenerate

  assign ram_we   = ram_cs & write;
  assign open_bus = cs_xram & ~ram_cs;

endmodule
`default_nettype wire

// File: tb/tb_lr35902_mbc1.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_lr35902_mbc1                                                  |
// | Purpose : Directed self-checking bench for lr35902_mbc1. Two instances     |
// |           share one CPU bus: dut (128 ROM / 4 RAM banks) and dut_s         |
// |           (32 ROM / 0 RAM banks). Expected values follow the macro         |
// |           LR35902_MBC1_MULTICART_EN when it is defined.                    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_lr35902_mbc1;

  logic        clk;
  logic        reset_n;
  logic [15:0] adr;
  logic [7:0]  din;
  logic        write;
  logic        cs_rom;
  logic        cs_xram;

  logic [20:0] rom_adr,  rom_adr_s;
  logic [14:0] ram_adr,  ram_adr_s;
  logic        ram_cs,   ram_cs_s;
  logic        ram_we,   ram_we_s;
  logic        open_bus, open_bus_s;

  int n_checks = 0;
  int n_errors = 0;

  lr35902_mbc1 #(.ROM_BANKS(128), .RAM_BANKS(4)) dut (
    .clk(clk), .reset_n(reset_n), .adr(adr), .din(din), .write(write),
    .cs_rom(cs_rom), .cs_xram(cs_xram), .rom_adr(rom_adr), .ram_adr(ram_adr),
    .ram_cs(ram_cs), .ram_we(ram_we), .open_bus(open_bus)
  );

  lr35902_mbc1 #(.ROM_BANKS(32), .RAM_BANKS(0)) dut_s (
    .clk(clk), .reset_n(reset_n), .adr(adr), .din(din), .write(write),
    .cs_rom(cs_rom), .cs_xram(cs_xram), .rom_adr(rom_adr_s), .ram_adr(ram_adr_s),
    .ram_cs(ram_cs_s), .ram_we(ram_we_s), .open_bus(open_bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Drive a bus address with the matching chip select, no write.
  task automatic bus_read(input logic [15:0] a);
    adr     = a;
    cs_rom  = ~a[15];
    cs_xram = (a[15:13] == 3'b101);
    write   = 1'b0;
    #1;
  endtask

  // One-cycle write pulse followed by one idle cycle.
  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    adr     = a;
    din     = d;
    cs_rom  = ~a[15];
    cs_xram = (a[15:13] == 3'b101);
    write   = 1'b1;
    @(posedge clk); #1;
    write   = 1'b0;
    cs_rom  = 1'b0;
    cs_xram = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0;
    adr = 16'h0000; din = 8'h00; write = 1'b0; cs_rom = 1'b0; cs_xram = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // 1. reset state
    bus_read(16'h4000);
    check_eq("rst_upper",  rom_adr, 21'h04000);
    bus_read(16'h0123);
    check_eq("rst_lower",  rom_adr, 21'h00123);
    bus_read(16'ha000);
    check_eq("rst_ram_cs", ram_cs, 1'b0);
    check_eq("rst_open",   open_bus, 1'b1);

    // 2. bank1 then bank2
    bus_write(16'h2000, 8'h05);
    bus_read(16'h4abc);
    check_eq("bank1_5", rom_adr, 21'h14abc);
    bus_write(16'h4000, 8'h02);
    bus_read(16'h4abc);
`ifdef LR35902_MBC1_MULTICART_EN
    check_eq("bank2_2", rom_adr, 21'h94abc);
`else
    check_eq("bank2_2", rom_adr, 21'h114abc);
`endif

    // 3. zero fix with bank2=1, then mode 1 lower area
    bus_write(16'h4000, 8'h01);
    bus_write(16'h2000, 8'h00);
    bus_read(16'h4000);
`ifdef LR35902_MBC1_MULTICART_EN
    check_eq("zero_fix", rom_adr, 21'h44000);
`else
    check_eq("zero_fix", rom_adr, 21'h84000);
`endif
    bus_write(16'h6000, 8'h01);
    bus_read(16'h0010);
`ifdef LR35902_MBC1_MULTICART_EN
    check_eq("mode1_lower", rom_adr, 21'h40010);
`else
    check_eq("mode1_lower", rom_adr, 21'h80010);
`endif
    // bank1=0x10 is non-zero over 5 bits, so no fix
    bus_write(16'h2000, 8'h10);
    bus_read(16'h4000);
`ifdef LR35902_MBC1_MULTICART_EN
    check_eq("b1_0x10", rom_adr, 21'h40000);
`else
    check_eq("b1_0x10", rom_adr, 21'hc0000);
`endif

    // 4. RAM enable, banked RAM write
    bus_write(16'h0000, 8'h0a);
    bus_write(16'h4000, 8'h03);
    adr = 16'ha123; din = 8'h07; cs_xram = 1'b1; cs_rom = 1'b0; write = 1'b1;
    #1;
    check_eq("ram_cs",     ram_cs,   1'b1);
    check_eq("ram_we",     ram_we,   1'b1);
    check_eq("ram_adr",    ram_adr,  15'h6123);
    check_eq("ram_open",   open_bus, 1'b0);
    check_eq("s_ram_cs",   ram_cs_s, 1'b0);
    check_eq("s_ram_we",   ram_we_s, 1'b0);
    check_eq("s_ram_adr",  ram_adr_s, 15'h0000);
    check_eq("s_open",     open_bus_s, 1'b1);
    @(posedge clk); #1;
    write = 1'b0; cs_xram = 1'b0;
    @(posedge clk); #1;
    // the xram write above must not have touched bank1
    bus_read(16'h4000);
`ifdef LR35902_MBC1_MULTICART_EN
    check_eq("xram_no_reg", rom_adr, 21'hc0000);
`else
    check_eq("xram_no_reg", rom_adr, 21'h1c0000);
`endif
    bus_write(16'h6000, 8'h00);
    bus_read(16'ha123);
    check_eq("mode0_ramadr", ram_adr, 15'h0123);
    check_eq("mode0_ramwe",  ram_we,  1'b0);
    bus_read(16'h0010);
    check_eq("mode0_lower",  rom_adr, 21'h00010);
    bus_write(16'h0000, 8'h00);
    bus_read(16'ha123);
    check_eq("dis_open",   open_bus, 1'b1);
    check_eq("dis_ram_cs", ram_cs,   1'b0);

    // 5. held write: only the first data value commits
    adr = 16'h2000; din = 8'h03; cs_rom = 1'b1; cs_xram = 1'b0; write = 1'b1;
    @(posedge clk); #1;
    din = 8'h07;
    repeat (3) @(posedge clk);
    #1 write = 1'b0;
    @(posedge clk); #1;
    bus_read(16'h4000);
`ifdef LR35902_MBC1_MULTICART_EN
    check_eq("held_write", rom_adr, 21'hcc000);
`else
    check_eq("held_write", rom_adr, 21'h18c000);
`endif
    // reset mid-hold clears everything (mode and banks)
    bus_write(16'h6000, 8'h01);
    adr = 16'h2000; din = 8'h06; cs_rom = 1'b1; write = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    bus_read(16'h4000);
    check_eq("rst_mid_upper", rom_adr, 21'h04000);
    bus_read(16'h0010);
    check_eq("rst_mid_lower", rom_adr, 21'h00010);
    // write held across reset release commits once
    adr = 16'h2000; din = 8'h06; cs_rom = 1'b1; write = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 write = 1'b0;
    @(posedge clk); #1;
    bus_read(16'h4000);
    check_eq("rst_release", rom_adr, 21'h18000);

    // 6. ROM mask on the 32-bank instance
    bus_write(16'h2000, 8'h1f);
    bus_write(16'h4000, 8'h03);
    bus_read(16'h4000);
    check_eq("s_mask", rom_adr_s, 21'h7c000);
`ifdef LR35902_MBC1_MULTICART_EN
    check_eq("full_1f3", rom_adr, 21'hfc000);
`else
    check_eq("full_1f3", rom_adr, 21'h1fc000);
`endif
    bus_write(16'h4000, 8'h01);
    bus_write(16'h2000, 8'h12);
    bus_read(16'h4000);
    check_eq("s_b12", rom_adr_s, 21'h48000);
`ifdef LR35902_MBC1_MULTICART_EN
    check_eq("full_b12", rom_adr, 21'h48000);
`else
    check_eq("full_b12", rom_adr, 21'hc8000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
